// File: rtl/lane_seq_pkg.sv
// Shared types and default widths for the lane sequencer slice.
package lane_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned LANE_IW_DEF = 16;
    localparam int unsigned LANE_OW_DEF = 4;

endpackage

// File: rtl/lane_seq_ctrl_if.sv
// Stream and lane-bank signals of the lane sequencer; master is the sequencer side.
interface lane_seq_ctrl_if #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned LANE_IW   = 16,
    parameter int unsigned LANE_OW   = 4
);
    logic                           IN_VALID;
    logic                           IN_READY;
    logic [NUM_LANES*LANE_IW-1:0]   IN_DATA;
    logic                           OUT_VALID;
    logic                           OUT_READY;
    logic [NUM_LANES*LANE_OW-1:0]   OUT_DATA;
    logic                           OUT_ERR;
    logic [NUM_LANES-1:0]           LANE_START;
    logic [NUM_LANES*LANE_IW-1:0]   LANE_DIN;
    logic [NUM_LANES*LANE_OW-1:0]   LANE_DOUT;
    logic [NUM_LANES-1:0]           LANE_BUSY;
    logic                           BUSY;

    modport master (
        input  IN_VALID, IN_DATA, OUT_READY, LANE_DOUT, LANE_BUSY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_ERR, LANE_START, LANE_DIN, BUSY
    );

    modport slave (
        output IN_VALID, IN_DATA, OUT_READY, LANE_DOUT, LANE_BUSY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_ERR, LANE_START, LANE_DIN, BUSY
    );
endinterface

// File: rtl/lane_seq_timer.sv
// WAIT-cycle counter: clears while i_clr, counts while i_en, flags the TIMEOUT-th cycle.
module lane_seq_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [15:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != '1) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // r_cnt holds the number of completed WAIT cycles, so TIMEOUT-1 marks the last one
    assign o_expire = i_en && (r_cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/lane_seq_ctrl.sv
// Splits one wide word across NUM_LANES lanes, starts them together and returns the joined result.
// Optional WAIT timeout abort is built when LANE_SEQ_TIMEOUT_EN is defined.
module lane_seq_ctrl
    import lane_seq_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned LANE_IW   = LANE_IW_DEF,
    parameter int unsigned LANE_OW   = LANE_OW_DEF,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    lane_seq_ctrl_if.master  bus
);
    if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
        $error("lane_seq_ctrl: NUM_LANES must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("lane_seq_ctrl: TIMEOUT must be 1..65535");
    end

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [NUM_LANES*LANE_IW-1:0]   r_din;
    logic [NUM_LANES*LANE_OW-1:0]   r_res;
    logic [NUM_LANES-1:0]           r_done;
    logic [NUM_LANES-1:0]           w_cap;
    logic                           w_all_done;
    logic                           w_expire;
    logic                           r_err;

`ifdef LANE_SEQ_TIMEOUT_EN
    lane_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_clr    (r_state != WAIT),
        .i_en     (r_state == WAIT),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = '0;
        if (r_state == WAIT) begin
            w_cap = ~r_done & ~bus.LANE_BUSY;
        end
        w_all_done = &(r_done | w_cap);
        unique case (r_state)
            IDLE:    if (bus.IN_VALID) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_all_done || w_expire) w_state_nxt = RESP;
            RESP:    if (bus.OUT_READY) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_din  <= '0;
            r_res  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
        end else if (r_state == IDLE && bus.IN_VALID) begin
            r_din  <= bus.IN_DATA;
            r_res  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
        end else if (r_state == WAIT) begin
            r_done <= r_done | w_cap;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (w_cap[i]) begin
                    r_res[i*LANE_OW +: LANE_OW] <= bus.LANE_DOUT[i*LANE_OW +: LANE_OW];
                end
            end
            // a lane finishing in the expiry cycle still counts, so only report leftovers
            r_err <= w_expire && !w_all_done;
        end
    end

    assign bus.IN_READY   = (r_state == IDLE);
    assign bus.OUT_VALID  = (r_state == RESP);
    assign bus.OUT_DATA   = r_res;
    assign bus.LANE_START = (r_state == ISSUE) ? '1 : '0;
    assign bus.LANE_DIN   = r_din;
    assign bus.BUSY       = (r_state != IDLE);
`ifdef LANE_SEQ_TIMEOUT_EN
    assign bus.OUT_ERR    = r_err;
`else
    assign bus.OUT_ERR    = 1'b0;
`endif
endmodule

// File: doc/lane_seq_ctrl.md
Name: lane_seq_ctrl

Overview:
- Sequencer for a bank of NUM_LANES slice-processing lanes. Each lane takes a 16-bit input slice and returns a 4-bit result, with a BUSY flag.
- Accepts one wide word over a valid/ready stream and splits it into per-lane slices.
- Starts all lanes together, waits for every lane to finish, then returns the concatenated result over a valid/ready stream.
- Sits between the upstream word source and the lane instances, replacing hard-wired lane connections.

Parameters:
- NUM_LANES, 2, number of lanes sequenced (1..8)
- LANE_IW, 16, input slice width per lane
- LANE_OW, 4, result width per lane
- TIMEOUT, 255, max WAIT cycles before abort (used only with the optional feature; 1..65535)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- IN_VALID  in  1  input word valid
- IN_READY  out  1  block can accept a word
- IN_DATA  in  NUM_LANES*LANE_IW  input word; lane i gets bits [i*LANE_IW +: LANE_IW]
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  downstream accepts result
- OUT_DATA  out  NUM_LANES*LANE_OW  result; lane i occupies [i*LANE_OW +: LANE_OW]
- OUT_ERR  out  1  result incomplete (timeout); qualified by OUT_VALID
- LANE_START  out  NUM_LANES  one-cycle start pulse per lane
- LANE_DIN  out  NUM_LANES*LANE_IW  registered slices to lanes
- LANE_DOUT  in  NUM_LANES*LANE_OW  lane results
- LANE_BUSY  in  NUM_LANES  lane busy flags
- BUSY  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock CLK. Reset RST_N is synchronous and active-low.
- Reset (RST_N low at any edge, in any state, including mid-operation):
  - state=IDLE
  - IN_READY=1 (after reset release), OUT_VALID=0, OUT_ERR=0, OUT_DATA=0
  - LANE_START=0, LANE_DIN=0, done mask=0, timer=0
  - Lanes are not notified; an in-flight lane result is discarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: register IN_DATA into LANE_DIN, clear done mask and result register, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - LANE_START = all ones; IN_READY=0.
  - Go to WAIT.
- WAIT:
  - Each cycle, every lane i with done[i]=0 and LANE_BUSY[i]=0: capture LANE_DOUT slice i into the result register, set done[i].
  - A lane is sampled starting the cycle after its START, never in the START cycle itself.
  - When all done bits would be set after this cycle's update, go to RESP.
- RESP:
  - OUT_VALID=1; OUT_DATA and OUT_ERR held stable until OUT_READY.
  - On OUT_VALID&OUT_READY: go to IDLE.
  - No new input is accepted in RESP; IN_READY rises the cycle after the output handshake.
- LANE_DIN: held stable from capture until the RESP handshake completes.
- Latency: input handshake at edge t → LANE_START high in cycle t+1. With lanes that are never busy, OUT_VALID is high in cycle t+3. Minimum input-to-input spacing is 4 cycles.
- Lanes with BUSY stuck at 0 are legal and complete in the first WAIT cycle.
- Lanes finishing in different cycles are each captured in their own completion cycle; later BUSY toggles on a done lane are ignored.
- OUT_READY held high in RESP gives a one-cycle RESP.
- OUT_DATA bits of a lane not yet done read 0.

Optional Feature:
- Macro: LANE_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with lanes still not done, go to RESP with OUT_ERR=1; unfinished lanes' result slices are 0.
  - A lane completing in the same cycle the timeout fires counts as done, and OUT_ERR is 0 if that lane was the last one outstanding.
- Undefined:
  - No counter exists; WAIT waits indefinitely; OUT_ERR is tied to 0.

Decomposition:
- Package lane_seq_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP), 2 bits
  - default width constants LANE_IW_DEF=16, LANE_OW_DEF=4
- One sub-module is natural: lane_seq_timer, the WAIT-cycle counter with clear/enable/expire. It is instantiated only under LANE_SEQ_TIMEOUT_EN.

Test Plan:
- Reset release, IN_DATA=32'h1234_ABCD with never-busy lanes returning DOUT 4'h5/4'hA, OUT_READY=1 → LANE_START=2'b11 one cycle later, OUT_DATA=8'hA5, OUT_VALID 3 cycles after the input handshake, OUT_ERR=0.
- Lane0 BUSY 2 cycles, lane1 BUSY 6 cycles after START → lane0 captured in WAIT cycle 3, lane1 in cycle 7; OUT_VALID only after lane1 completes; OUT_DATA contains both slices.
- Downstream backpressure: OUT_READY=0 for 5 cycles in RESP → OUT_VALID, OUT_DATA and LANE_DIN stable; IN_READY=0 throughout; IN_READY=1 the cycle after the handshake.
- RST_N low for 1 cycle during WAIT with lane1 busy → next cycle IDLE, IN_READY=1, OUT_VALID=0, LANE_DIN=0; a new word 32'hFFFF_0000 then completes normally.
- With LANE_SEQ_TIMEOUT_EN, TIMEOUT=10, lane1 BUSY stuck high → RESP after 10 WAIT cycles, OUT_ERR=1, lane1 slice=0, lane0 slice correct.
- Back-to-back words with IN_VALID held high and 4 distinct values → 4 results in order, input accepted every 4 cycles, no LANE_START overlap.
